// File: rtl/textmode_pkg.sv
//======================================================================
// Module : textmode_pkg
// Brief  : Shared geometry, cell type and slot encoding for the text VRAM scheduler.
// Rev    : 1.0
//======================================================================
`default_nettype none

package textmode_pkg;
    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int CELL_W      = 8;
    localparam int CELL_H      = 16;
    localparam int COLS        = H_RES / CELL_W;
    localparam int ROWS        = V_RES / CELL_H;
    localparam int AW          = 12;
    localparam int COL_W       = 7;
    localparam int CELL_W_LOG2 = $clog2(CELL_W);
    localparam int CELL_H_LOG2 = $clog2(CELL_H);

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        HRD  = 2'd2,
        HWR  = 2'd3
    } slot_t;
endpackage

`default_nettype wire

// File: rtl/textmode_vram_sched.sv
//======================================================================
// Module : textmode_vram_sched
// Brief  : Single-port text VRAM scheduler; display cell fetch has priority, host fills spare cycles.
// Rev    : 1.0
//======================================================================
`default_nettype none

module textmode_vram_sched
    import textmode_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    line,
    input  logic                    frame,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [AW-1:0]           req_addr,
    input  logic [15:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [15:0]             rsp_rdata,
    output logic                    vram_en,
    output logic                    vram_we,
    output logic [AW-1:0]           vram_addr,
    output logic [15:0]             vram_wdata,
    input  logic [15:0]             vram_rdata,
    output logic                    cell_valid,
    output logic [COL_W-1:0]        cell_col,
    output logic [15:0]             cell_data
);

    localparam logic signed [CORDW-1:0] c_SX_FIRST = CORDW'(-(CELL_W + 1));
    localparam logic signed [CORDW-1:0] c_SX_LAST  = CORDW'(H_RES - CELL_W - 9);
    localparam logic signed [CORDW-1:0] c_V_RES    = CORDW'(V_RES);
    localparam logic signed [CORDW-1:0] c_ZERO     = '0;
    localparam logic [AW-1:0]           c_CELLS    = AW'(COLS * ROWS);
    localparam logic [AW-1:0]           c_COLS     = AW'(COLS);

    logic             w_in_rows;
    logic             w_disp_slot;
    logic             w_row_step;
    logic             w_accept;
    logic             w_oor;
    logic [COL_W-1:0] w_col;

    slot_t            r_slot;
    slot_t            r_slot_s2;
    logic [COL_W-1:0] r_col_s1;
    logic [COL_W-1:0] r_col_s2;
    logic             r_oor_s1;
    logic             r_oor_s2;
    logic [AW-1:0]    r_row_base;

    logic             r_vram_en;
    logic             r_vram_we;
    logic [AW-1:0]    r_vram_addr;
    logic [15:0]      r_vram_wdata;
    logic             r_cell_valid;
    logic [COL_W-1:0] r_cell_col;
    cell_t            r_cell_data;
    logic             r_rsp_valid;
    logic [15:0]      r_rsp_rdata;

    // The decision cycle for column c sits at sx = 8c-9, so the column is (sx+9)/8.
    assign w_in_rows   = (sy >= c_ZERO) && (sy < c_V_RES);
    assign w_disp_slot = w_in_rows
                      && (sx[CELL_W_LOG2-1:0] == CELL_W_LOG2'(CELL_W - 1))
                      && (sx >= c_SX_FIRST) && (sx <= c_SX_LAST);
    assign w_col       = COL_W'((sx - c_SX_FIRST) >>> CELL_W_LOG2);
    assign w_row_step  = line && (sy > c_ZERO) && (sy < c_V_RES)
                      && (sy[CELL_H_LOG2-1:0] == '0);
    assign w_oor       = (req_addr >= c_CELLS);
    assign req_ready   = ~rst_pix & ~w_disp_slot;
    assign w_accept    = req_valid & req_ready;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_slot       <= IDLE;
            r_slot_s2    <= IDLE;
            r_col_s1     <= '0;
            r_col_s2     <= '0;
            r_oor_s1     <= 1'b0;
            r_oor_s2     <= 1'b0;
            r_row_base   <= '0;
            r_vram_en    <= 1'b0;
            r_vram_we    <= 1'b0;
            r_vram_addr  <= '0;
            r_vram_wdata <= '0;
            r_cell_valid <= 1'b0;
            r_cell_col   <= '0;
            r_cell_data  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            if (frame || (line && sy == c_ZERO)) begin
                r_row_base <= '0;
            end else if (w_row_step) begin
                r_row_base <= r_row_base + c_COLS;
            end

            // Stage 1: slot decision and VRAM command.
            r_vram_en <= 1'b0;
            r_vram_we <= 1'b0;
            r_oor_s1  <= 1'b0;
            if (w_disp_slot) begin
                r_slot      <= DISP;
                r_vram_en   <= 1'b1;
                r_vram_addr <= r_row_base + AW'(w_col);
                r_col_s1    <= w_col;
            end else if (w_accept) begin
                r_slot       <= req_we ? HWR : HRD;
                r_vram_en    <= ~w_oor;
                r_vram_we    <= req_we & ~w_oor;
                r_vram_addr  <= req_addr;
                r_vram_wdata <= req_wdata;
                r_oor_s1     <= w_oor;
            end else begin
                r_slot <= IDLE;
            end

            // Stage 2: VRAM read data is valid while this stage is occupied.
            r_slot_s2 <= r_slot;
            r_col_s2  <= r_col_s1;
            r_oor_s2  <= r_oor_s1;

            r_cell_valid <= (r_slot_s2 == DISP);
            if (r_slot_s2 == DISP) begin
                r_cell_col  <= r_col_s2;
                r_cell_data <= cell_t'(vram_rdata);
            end

            r_rsp_valid <= (r_slot_s2 == HRD);
            if (r_slot_s2 == HRD) begin
                r_rsp_rdata <= r_oor_s2 ? 16'h0000 : vram_rdata;
            end
        end
    end

    assign vram_en    = r_vram_en;
    assign vram_we    = r_vram_we;
    assign vram_addr  = r_vram_addr;
    assign vram_wdata = r_vram_wdata;
    assign cell_valid = r_cell_valid;
    assign cell_col   = r_cell_col;
    assign cell_data  = r_cell_data;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_textmode_vram_sched.sv
//======================================================================
// Module : tb_textmode_vram_sched
// Brief  : Directed self-checking bench with a behavioural VRAM and host transaction table.
// Rev    : 1.0
//======================================================================
`default_nettype none

module tb_textmode_vram_sched;
    import textmode_pkg::*;

    localparam int CORDW = 16;

    logic                    clk_pix = 1'b0;
    logic                    rst_pix;
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sy;
    logic                    line;
    logic                    frame;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [AW-1:0]           req_addr;
    logic [15:0]             req_wdata;
    logic                    rsp_valid;
    logic [15:0]             rsp_rdata;
    logic                    vram_en;
    logic                    vram_we;
    logic [AW-1:0]           vram_addr;
    logic [15:0]             vram_wdata;
    logic [15:0]             vram_rdata = '0;
    logic                    cell_valid;
    logic [COL_W-1:0]        cell_col;
    logic [15:0]             cell_data;

    logic                    preload;
    logic [15:0]             mem [0:4095];

    int total = 0;
    int bad   = 0;

    always #5 clk_pix = ~clk_pix;

    textmode_vram_sched #(.CORDW(CORDW)) dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .sx         (sx),
        .sy         (sy),
        .line       (line),
        .frame      (frame),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .vram_en    (vram_en),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .cell_valid (cell_valid),
        .cell_col   (cell_col),
        .cell_data  (cell_data)
    );

    function automatic logic [15:0] exp_init(input int a);
        if (a < COLS)       return 16'(a);
        else if (a == COLS) return 16'hA541;
        else                return 16'hC000 | 16'(a);
    endfunction

    // Synchronous single-port VRAM with one cycle read latency.
    always @(posedge clk_pix) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= exp_init(i);
        end else if (vram_en) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else         vram_rdata     <= mem[vram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic blank_pos();
        sx = CORDW'(-100);
        sy = CORDW'(-10);
    endtask

    task automatic pulse_frame();
        blank_pos();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic pulse_lines(input int y0, input int y1);
        sx = CORDW'(-100);
        for (int y = y0; y <= y1; y++) begin
            sy   = CORDW'(y);
            line = 1'b1;
            tick();
        end
        line = 1'b0;
        blank_pos();
    endtask

    // One full 800-clock line; checks every cycle against the cell/ready schedule.
    task automatic scan_line(input int y, input logic hold,
                             output int n_cells, output int n_acc, output int n_rsp);
        int  base;
        logic exp_cv;
        logic exp_rdy;
        base    = (y / CELL_H) * COLS;
        n_cells = 0;
        n_acc   = 0;
        n_rsp   = 0;
        sy      = CORDW'(y);
        for (int x = -160; x < 640; x++) begin
            sx        = CORDW'(x);
            line      = (x == -160);
            req_valid = hold;
            req_we    = 1'b0;
            req_addr  = 12'd7;
            req_wdata = 16'h0000;
            #1;
            exp_cv = (y >= 0) && (y < V_RES) && (x >= -6) && (x <= 626) && (((x + 6) % 8) == 0);
            check("cell_valid", {31'd0, cell_valid}, {31'd0, exp_cv});
            if (cell_valid) n_cells++;
            if (exp_cv && cell_valid) begin
                check("cell_col", 32'(cell_col), 32'((x + 6) / 8));
                check("cell_data", 32'(cell_data), 32'(exp_init(base + (x + 6) / 8)));
            end
            exp_rdy = !((y >= 0) && (y < V_RES) && (x >= -9) && (x <= 623) && (((x + 9) % 8) == 0));
            check("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
            if (hold && req_ready) n_acc++;
            if (rsp_valid) n_rsp++;
            tick();
        end
        line      = 1'b0;
        req_valid = 1'b0;
        blank_pos();
        for (int k = 0; k < 4; k++) begin
            #1;
            if (rsp_valid) n_rsp++;
            tick();
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [15:0]   exp_rd;
    } hvec_t;

    localparam int NV = 10;
    hvec_t hv [NV];

    initial begin
        int  nc, na, nr;
        logic seen;

        hv[0] = '{1'b1, 12'd5,    16'h1234, 16'h0000};
        hv[1] = '{1'b0, 12'd5,    16'h0000, 16'h1234};
        hv[2] = '{1'b1, 12'd2400, 16'hBEEF, 16'h0000};
        hv[3] = '{1'b0, 12'd2400, 16'h0000, 16'h0000};
        hv[4] = '{1'b1, 12'd2399, 16'h5A5A, 16'h0000};
        hv[5] = '{1'b0, 12'd2399, 16'h0000, 16'h5A5A};
        hv[6] = '{1'b0, 12'd80,   16'h0000, 16'hA541};
        hv[7] = '{1'b0, 12'd4095, 16'h0000, 16'h0000};
        hv[8] = '{1'b1, 12'd0,    16'hFFFF, 16'h0000};
        hv[9] = '{1'b0, 12'd0,    16'h0000, 16'hFFFF};

        rst_pix   = 1'b1;
        preload   = 1'b1;
        line      = 1'b0;
        frame     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        blank_pos();
        tick();
        preload = 1'b0;
        tick();
        tick();

        check("rst_req_ready",  {31'd0, req_ready},  32'd0);
        check("rst_vram_en",    {31'd0, vram_en},    32'd0);
        check("rst_cell_valid", {31'd0, cell_valid}, 32'd0);
        check("rst_cell_data",  32'(cell_data),      32'd0);
        check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        rst_pix = 1'b0;
        tick();

        // Read accepted, then reset on the following cycle: the response must vanish.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'd3;
        tick();
        check("mid_vram_en", {31'd0, vram_en}, 32'd1);
        req_valid = 1'b0;
        rst_pix   = 1'b1;
        tick();
        check("mid_rst_outputs",
              {7'd0, req_ready, rsp_valid, vram_en, vram_we, cell_valid, 20'(cell_col) | 20'(vram_addr)},
              32'd0);
        check("mid_rst_data", {rsp_rdata, cell_data | vram_wdata}, 32'd0);
        rst_pix = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_rst_rsp_dropped", {31'd0, seen}, 32'd0);

        pulse_frame();
        scan_line(0, 1'b0, nc, na, nr);
        check("row0_cells", 32'(nc), 32'd80);

        pulse_lines(1, 15);
        scan_line(16, 1'b0, nc, na, nr);
        check("row16_cells", 32'(nc), 32'd80);

        pulse_lines(17, 478);
        scan_line(479, 1'b0, nc, na, nr);
        check("row479_cells", 32'(nc), 32'd80);

        scan_line(480, 1'b0, nc, na, nr);
        check("row480_cells", 32'(nc), 32'd0);

        pulse_frame();
        scan_line(0, 1'b1, nc, na, nr);
        check("hold_cells",   32'(nc), 32'd80);
        check("hold_accepts", 32'(na), 32'd720);
        check("hold_rsps",    32'(nr), 32'd720);

        for (int i = 0; i < NV; i++) begin
            logic inr;
            inr = (hv[i].addr < 12'(COLS * ROWS));
            blank_pos();
            req_valid = 1'b1;
            req_we    = hv[i].we;
            req_addr  = hv[i].addr;
            req_wdata = hv[i].wdata;
            #1;
            check("h_ready", {31'd0, req_ready}, 32'd1);
            tick();
            req_valid = 1'b0;
            check("h_vram_en", {31'd0, vram_en}, {31'd0, inr});
            if (inr) begin
                check("h_vram_we",   {31'd0, vram_we}, {31'd0, hv[i].we});
                check("h_vram_addr", 32'(vram_addr),   32'(hv[i].addr));
                if (hv[i].we) check("h_vram_wdata", 32'(vram_wdata), 32'(hv[i].wdata));
            end
            tick();
            check("h_rsp_early", {31'd0, rsp_valid}, 32'd0);
            tick();
            check("h_rsp_valid", {31'd0, rsp_valid}, {31'd0, ~hv[i].we});
            if (!hv[i].we) check("h_rsp_rdata", 32'(rsp_rdata), 32'(hv[i].exp_rd));
            tick();
            check("h_rsp_late", {31'd0, rsp_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
